stoch_signed_patch_scanner: RTL
===============================

Name: stoch_signed_patch_scanner

Overview:
- Captures one bit-slice of a signed stochastic feature map (p/m rails, HEIGHT x WIDTH x CHANNELS) on a start pulse.
- Emits every convolution-window patch of that slice sequentially over a valid/ready stream, with configurable stride, zero-padding and output layout.
- Sits between a conv layer's input buffer and a time-multiplexed stochastic MAC array, so one MAC array serves all output positions.

Parameters:
- WIDTH, 32, input map width
- HEIGHT, 32, input map height
- CHANNELS, 3, input channels
- PATCH_W, 3, window width
- PATCH_H, 3, window height
- STRIDE_W, 1, horizontal step (>=1)
- STRIDE_H, 1, vertical step (>=1)
- PAD_W, 0, left/right padding columns
- PAD_H, 0, top/bottom padding rows
- DEFAULT, 1'b0, bit value driven on both rails for padded positions
- REV, 0, output layout: 0 = PATCH_H x PATCH_W x CHANNELS, 1 = CHANNELS x PATCH_H x PATCH_W

Ports:
- CLK  in  1  clock
- RST  in  1  reset; synchronous, active-high (clock CLK, reset RST; polarity and synchronicity fixed)
- start  in  1  capture in_p/in_m and begin scan; honoured only in IDLE
- in_p  in  HEIGHT*WIDTH*CHANNELS  plus rail, packed [H][W][C]
- in_m  in  HEIGHT*WIDTH*CHANNELS  minus rail, packed [H][W][C]
- patch_p  out  PATCH_H*PATCH_W*CHANNELS  plus-rail patch, packed per REV
- patch_m  out  PATCH_H*PATCH_W*CHANNELS  minus-rail patch, packed per REV
- patch_row  out  ROW_W  output-row index of the current patch
- patch_col  out  COL_W  output-column index of the current patch
- patch_valid  out  1  patch/index outputs valid
- patch_ready  in  1  consumer accepts the patch
- patch_last  out  1  current patch is the final one (OUT_H-1, OUT_W-1)
- busy  out  1  high in FILL and SCAN
- done  out  1  one-cycle pulse after the last handshake

Behaviour:
- Derived sizes: OUT_H = (HEIGHT+2*PAD_H-PATCH_H)/STRIDE_H+1 and OUT_W = (WIDTH+2*PAD_W-PATCH_W)/STRIDE_W+1, both floor division. ROW_W = max(1,$clog2(OUT_H)); COL_W likewise from OUT_W.
- Elaboration $error if any of these hold: STRIDE < 1, PATCH > dim+2*PAD, or any parameter negative.
- Patch origin (signed): base_h = r*STRIDE_H - PAD_H; base_w = c*STRIDE_W - PAD_W.
- Element (i,j,ch) = frame[base_h+i][base_w+j][ch] when 0 <= base_h+i < HEIGHT and 0 <= base_w+j < WIDTH; otherwise DEFAULT on both rails.
- Layout REV=1: patch[ch][i][j] holds the element. REV=0: patch[i][j][ch] holds the element.
- Frame registers frame_p/frame_m are loaded only on start accepted in IDLE. in_p/in_m are ignored at all other times.
- FSM states: IDLE, FILL, SCAN, DONE.
- IDLE: on start, capture frame, r=c=0, go to FILL. Otherwise stay.
- FILL: register patch (0,0) and its indices; set patch_valid=1; go to SCAN. Start-to-valid latency is 2 edges.
- SCAN: patch_valid held 1. Outputs are stable while patch_ready=0.
  - On valid&&ready with patch_last=0: advance c, wrapping to 0 and incrementing r at OUT_W-1. The next patch registers on the same edge, so throughput is 1 patch/cycle under continuous ready.
  - On valid&&ready with patch_last=1: go to DONE, patch_valid->0.
- DONE: done=1 for one cycle, then IDLE.
- start outside IDLE is ignored; no queuing.
- A start in the DONE cycle is also ignored. The earliest restart is the following cycle.
- OUT_H=OUT_W=1: patch_last=1 on the first valid.
- Reset (any state, including mid-scan): state=IDLE, patch_valid=0, patch_last=0, busy=0, done=0, r=c=0. patch_p, patch_m, patch_row, patch_col and frame registers are all cleared to 0. No in-flight patch survives reset.
- Registered outputs: patch_p, patch_m, patch_row, patch_col, patch_valid, patch_last, done.
- Combinational outputs: busy = (state==FILL||state==SCAN).

Decomposition:
- Package stoch_patch_pkg holds:
  - the FSM state enum scan_state_t;
  - constant functions out_dim(dim,patch,stride,pad) and idx_width(n);
  - the layout-mode localparams LAYOUT_HWC=0 and LAYOUT_CHW=1.
- One combinational sub-module, stoch_signed_patch_select. Parameters: WIDTH, HEIGHT, CHANNELS, PATCH_W, PATCH_H, DEFAULT, REV. Inputs: frame_p, frame_m and signed base_h/base_w ports. Outputs: the patch rails.
- The top contains the FSM, counters and output registers.

Test Plan:
- W=H=4, C=1, patch 3x3, stride 1, pad 0, frame_p=16'h1234, frame_m=0, ready=1 -> valid 2 cycles after start; 4 patches (0,0),(0,1),(1,0),(1,1) on consecutive cycles; last on 4th; done the cycle after; each patch equals the reference-model slice.
- Same map, pad 1 -> 16 patches; patch (0,0) row 0 and column 0 all DEFAULT, centre bit = in[0][0]; run with DEFAULT=1 -> padded positions 1 on both rails.
- W=H=5, stride 2, pad 0 -> OUT 2x2; patch (1,1) origin (2,2); index ports 0..1.
- Backpressure: ready toggled 1,0,0,1 -> patch/index held over stall cycles; no skipped or duplicated index; new start during SCAN ignored with frame unchanged.
- RST asserted on 3rd SCAN cycle -> next edge valid=0, busy=0, outputs 0; fresh start rescans from (0,0).
- C=12, REV=1 vs REV=0 on the same frame -> patch[ch][i][j] (REV=1) equals patch[i][j][ch] (REV=0) for all ch 0..11.

Source files
------------

// File: rtl/stoch_signed_patch_scanner_pkg.sv
// Shared types and sizing helpers for the signed stochastic patch scanner.
// Imported by the scanner top and its patch-select datapath.
package stoch_patch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    SCAN,
    DONE
  } scan_state_t;

  localparam int LAYOUT_HWC = 0;
  localparam int LAYOUT_CHW = 1;
  localparam int BASE_W     = 16;

  // Degenerate configs return 1 so elaboration reaches the parameter check.
  function automatic int out_dim(
    input int dim,
    input int patch,
    input int stride,
    input int pad
  );
    if (stride < 1 || patch > dim + 2 * pad)
      return 1;
    return (dim + 2 * pad - patch) / stride + 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stoch_signed_patch_scanner_select.sv
// Combinational window extractor: one patch of both rails at a signed origin.
// Out-of-frame taps read DEFAULT on both rails.
module stoch_signed_patch_select
  import stoch_patch_pkg::*;
#(
  parameter int   WIDTH    = 32,
  parameter int   HEIGHT   = 32,
  parameter int   CHANNELS = 3,
  parameter int   PATCH_W  = 3,
  parameter int   PATCH_H  = 3,
  parameter logic DEFAULT  = 1'b0,
  parameter int   REV      = 0
) (
  input  logic [HEIGHT*WIDTH*CHANNELS-1:0]    frame_p,
  input  logic [HEIGHT*WIDTH*CHANNELS-1:0]    frame_m,
  input  logic signed [BASE_W-1:0]            base_h,
  input  logic signed [BASE_W-1:0]            base_w,
  output logic [PATCH_H*PATCH_W*CHANNELS-1:0] patch_p,
  output logic [PATCH_H*PATCH_W*CHANNELS-1:0] patch_m
);

  localparam int SW = idx_width(HEIGHT * WIDTH * CHANNELS);

  for (genvar i = 0; i < PATCH_H; i++) begin : g_i
    int hh;
    assign hh = int'(base_h) + i;
    for (genvar j = 0; j < PATCH_W; j++) begin : g_j
      int   ww;
      logic inr;
      assign ww  = int'(base_w) + j;
      assign inr = (hh >= 0) && (hh < HEIGHT)
                && (ww >= 0) && (ww < WIDTH);
      for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        localparam int DST = (REV == LAYOUT_CHW)
          ? (ch * PATCH_H + i) * PATCH_W + j
          : (i * PATCH_W + j) * CHANNELS + ch;
        logic [SW-1:0] sidx;
        assign sidx = SW'((hh * WIDTH + ww) * CHANNELS + ch);
        assign patch_p[DST] = inr ? frame_p[sidx] : DEFAULT;
        assign patch_m[DST] = inr ? frame_m[sidx] : DEFAULT;
      end
    end
  end

endmodule

// File: rtl/stoch_signed_patch_scanner.sv
// Captures one bit-slice of a signed stochastic map and streams every
// convolution window over valid/ready, one patch per cycle.
module stoch_signed_patch_scanner
  import stoch_patch_pkg::*;
#(
  parameter int   WIDTH    = 32,
  parameter int   HEIGHT   = 32,
  parameter int   CHANNELS = 3,
  parameter int   PATCH_W  = 3,
  parameter int   PATCH_H  = 3,
  parameter int   STRIDE_W = 1,
  parameter int   STRIDE_H = 1,
  parameter int   PAD_W    = 0,
  parameter int   PAD_H    = 0,
  parameter logic DEFAULT  = 1'b0,
  parameter int   REV      = 0,
  localparam int  OUT_H = out_dim(HEIGHT, PATCH_H, STRIDE_H, PAD_H),
  localparam int  OUT_W = out_dim(WIDTH, PATCH_W, STRIDE_W, PAD_W),
  localparam int  ROW_W = idx_width(OUT_H),
  localparam int  COL_W = idx_width(OUT_W),
  localparam int  FN    = HEIGHT * WIDTH * CHANNELS,
  localparam int  PN    = PATCH_H * PATCH_W * CHANNELS
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [FN-1:0]    in_p,
  input  logic [FN-1:0]    in_m,
  output logic [PN-1:0]    patch_p,
  output logic [PN-1:0]    patch_m,
  output logic [ROW_W-1:0] patch_row,
  output logic [COL_W-1:0] patch_col,
  output logic             patch_valid,
  input  logic             patch_ready,
  output logic             patch_last,
  output logic             busy,
  output logic             done
);

  if (STRIDE_W < 1 || STRIDE_H < 1
      || WIDTH < 0 || HEIGHT < 0 || CHANNELS < 0
      || PATCH_W < 0 || PATCH_H < 0 || PAD_W < 0 || PAD_H < 0
      || PATCH_W > WIDTH + 2 * PAD_W
      || PATCH_H > HEIGHT + 2 * PAD_H) begin : g_param_err
    $error("stoch_signed_patch_scanner: illegal parameter set");
  end

  scan_state_t             state, nstate;
  logic [FN-1:0]           frame_p, frame_m;
  logic [PN-1:0]           sel_p, sel_m;
  logic [ROW_W-1:0]        tr;
  logic [COL_W-1:0]        tc;
  logic                    tlast;
  logic                    fire, capture, load;
  logic signed [BASE_W-1:0] base_h, base_w;

  assign fire = patch_valid && patch_ready;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (start) nstate = FILL;
      FILL:    nstate = SCAN;
      SCAN:    if (fire && patch_last) nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    capture = 1'b0;
    load    = 1'b0;
    unique case (state)
      IDLE: capture = start;
      FILL: begin
        busy = 1'b1;
        load = 1'b1;
      end
      SCAN: begin
        busy = 1'b1;
        load = fire && !patch_last;
      end
      default: ;
    endcase
  end

  // Target is the patch registered on the next load: (0,0) in FILL,
  // raster successor of the current index in SCAN.
  always_comb begin
    tr = '0;
    tc = '0;
    if (state == SCAN) begin
      if (patch_col == COL_W'(OUT_W - 1)) begin
        tr = patch_row + 1'b1;
      end else begin
        tr = patch_row;
        tc = patch_col + 1'b1;
      end
    end
    tlast  = (tr == ROW_W'(OUT_H - 1))
          && (tc == COL_W'(OUT_W - 1));
    base_h = BASE_W'(int'(tr) * STRIDE_H - PAD_H);
    base_w = BASE_W'(int'(tc) * STRIDE_W - PAD_W);
  end

  stoch_signed_patch_select #(
    .WIDTH    (WIDTH),
    .HEIGHT   (HEIGHT),
    .CHANNELS (CHANNELS),
    .PATCH_W  (PATCH_W),
    .PATCH_H  (PATCH_H),
    .DEFAULT  (DEFAULT),
    .REV      (REV)
  ) u_sel (
    .frame_p (frame_p),
    .frame_m (frame_m),
    .base_h  (base_h),
    .base_w  (base_w),
    .patch_p (sel_p),
    .patch_m (sel_m)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      frame_p     <= '0;
      frame_m     <= '0;
      patch_p     <= '0;
      patch_m     <= '0;
      patch_row   <= '0;
      patch_col   <= '0;
      patch_valid <= 1'b0;
      patch_last  <= 1'b0;
      done        <= 1'b0;
    end else begin
      if (capture) begin
        frame_p   <= in_p;
        frame_m   <= in_m;
        patch_row <= '0;
        patch_col <= '0;
      end
      if (load) begin
        patch_p     <= sel_p;
        patch_m     <= sel_m;
        patch_row   <= tr;
        patch_col   <= tc;
        patch_last  <= tlast;
        patch_valid <= 1'b1;
      end else if (state == SCAN && fire) begin
        patch_valid <= 1'b0;
        patch_last  <= 1'b0;
      end
      done <= (state == SCAN) && fire && patch_last;
    end
  end

endmodule
